// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One operation in flight: accept, execute, hold response until consumed.
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_op1,
  input  logic [WIDTH-1:0] req0_op2,
  input  logic [SEL_W-1:0] req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_op1,
  input  logic [WIDTH-1:0] req1_op2,
  input  logic [SEL_W-1:0] req1_sel,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_res,
  output logic             rsp_zf,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_zf,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_last;
  logic             r_gnt;
  logic [WIDTH-1:0] r_op1;
  logic [WIDTH-1:0] r_op2;
  logic [SEL_W-1:0] r_sel;
  logic [WIDTH-1:0] r_res;
  logic             r_zf;
  logic             r_err;

  logic             w_any;
  logic             w_gnt;
  logic             w_accept;
  logic             w_fire;
  logic             w_illegal;

  // Grant: single requester wins outright, a tie goes to the one not served last.
  always_comb begin
    w_any = req0_valid | req1_valid;
    w_gnt = (req0_valid && req1_valid) ? ~r_last : req1_valid;
  end

  // Select codes the ALU actually implements.
  always_comb begin
    w_illegal = !(r_sel inside {
      SEL_W'(0), SEL_W'(1), SEL_W'(2),
      SEL_W'(6), SEL_W'(7), SEL_W'(12)});
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next state and handshake outputs.
  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_fire     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_accept   = 1'b1;
          req0_ready = ~w_gnt;
          req1_ready = w_gnt;
          w_next     = EXEC;
        end
      end
      EXEC: w_next = RESP;
      RESP: begin
        rsp0_valid = ~r_gnt;
        rsp1_valid = r_gnt;
        w_fire = r_gnt ? rsp1_ready : rsp0_ready;
        if (w_fire) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Latch the winning request on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
      r_gnt  <= 1'b0;
      r_op1  <= '0;
      r_op2  <= '0;
      r_sel  <= '0;
    end else if (w_accept) begin
      r_last <= w_gnt;
      r_gnt  <= w_gnt;
      r_op1  <= w_gnt ? req1_op1 : req0_op1;
      r_op2  <= w_gnt ? req1_op2 : req0_op2;
      r_sel  <= w_gnt ? req1_sel : req0_sel;
    end
  end

  // Capture the ALU outcome at the end of the execute cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res <= '0;
      r_zf  <= 1'b0;
      r_err <= 1'b0;
    end else if (r_state == EXEC) begin
      r_res <= alu_res;
      r_zf  <= alu_zf;
      r_err <= w_illegal;
    end
  end

  assign alu_op1 = r_op1;
  assign alu_op2 = r_op2;
  assign alu_sel = r_sel;
  assign rsp_res = r_res;
  assign rsp_zf  = r_zf;
  assign rsp_err = r_err;
  assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: transaction model, vector table,
// corner sequences and random traffic.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 0, req1_valid = 0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_op1 = 0, req0_op2 = 0;
  logic [31:0] req1_op1 = 0, req1_op2 = 0;
  logic [3:0]  req0_sel = 0, req1_sel = 0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 0, rsp1_ready = 0;
  logic [31:0] rsp_res;
  logic        rsp_zf, rsp_err;
  logic [31:0] alu_op1, alu_op2, alu_res;
  logic [3:0]  alu_sel;
  logic        alu_zf;
  logic        busy;

  int n_tot = 0;
  int n_pass = 0;
  int cyc = 0;

  alu_share_arbiter #(.WIDTH(32), .SEL_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_sel(req1_sel),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_res(rsp_res), .rsp_zf(rsp_zf), .rsp_err(rsp_err),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_sel(alu_sel),
    .alu_res(alu_res), .alu_zf(alu_zf), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(
    input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
    case (s)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit legal(input logic [3:0] s);
    return s inside {4'b0000, 4'b0001, 4'b0010,
                     4'b0110, 4'b0111, 4'b1100};
  endfunction

  // Combinational ALU seen by the DUT.
  always_comb begin
    alu_res = ref_alu(alu_op1, alu_op2, alu_sel);
    alu_zf  = (alu_res == 32'd0);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d act=%h exp=%h", nm, cyc, act, exp);
  endtask

  // Transaction model: owner of the in-flight op (-1 none),
  // cycles since its acceptance, and its predicted outcome.
  int          m_own;
  int          m_age;
  bit          m_last;
  logic [31:0] m_op1, m_op2, m_res;
  logic [3:0]  m_sel;
  bit          m_zf, m_err;
  int          gq[$];
  int          gc[$];

  task automatic model_reset();
    m_own = -1; m_age = 0; m_last = 1'b1;
    m_op1 = 0; m_op2 = 0; m_sel = 0;
    m_res = 0; m_zf = 0; m_err = 0;
  endtask

  // Check this cycle against the model, then advance one clock.
  task automatic step();
    bit idle, any, g, resp;
    #1;
    idle = (m_own < 0);
    any  = req0_valid | req1_valid;
    g    = (req0_valid && req1_valid) ? !m_last : req1_valid;
    resp = !idle && (m_age >= 2);
    chk("req0_ready", req0_ready, idle && any && !g);
    chk("req1_ready", req1_ready, idle && any && g);
    chk("rsp0_valid", rsp0_valid, resp && m_own == 0);
    chk("rsp1_valid", rsp1_valid, resp && m_own == 1);
    chk("busy", busy, !idle);
    chk("alu_op1", alu_op1, m_op1);
    chk("alu_op2", alu_op2, m_op2);
    chk("alu_sel", alu_sel, m_sel);
    if (resp) begin
      chk("rsp_res", rsp_res, m_res);
      chk("rsp_zf", rsp_zf, m_zf);
      chk("rsp_err", rsp_err, m_err);
    end
    if (req0_ready) begin gq.push_back(0); gc.push_back(cyc); end
    if (req1_ready) begin gq.push_back(1); gc.push_back(cyc); end
    if (idle && any) begin
      m_own = g; m_last = g; m_age = 1;
      m_op1 = g ? req1_op1 : req0_op1;
      m_op2 = g ? req1_op2 : req0_op2;
      m_sel = g ? req1_sel : req0_sel;
      m_res = ref_alu(m_op1, m_op2, m_sel);
      m_zf  = (m_res == 0);
      m_err = !legal(m_sel);
    end else if (!idle && m_age == 1) begin
      m_age = 2;
    end else if (resp) begin
      if ((m_own == 0 && rsp0_ready) || (m_own == 1 && rsp1_ready))
        m_own = -1;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0;
    rsp0_ready = 0; rsp1_ready = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  sel;
    logic [31:0] res;
    logic        zf;
    logic        err;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{32'd5, 32'd7, 4'b0010, 32'd12, 1'b0, 1'b0};
    tbl[1] = '{32'd9, 32'd9, 4'b0110, 32'd0, 1'b1, 1'b0};
    tbl[2] = '{32'd3, 32'd9, 4'b0111, 32'd1, 1'b0, 1'b0};
    tbl[3] = '{32'hF0F0F0F0, 32'hFF00FF00, 4'b0000, 32'hF000F000, 1'b0, 1'b0};
    tbl[4] = '{32'd1, 32'd2, 4'b0001, 32'd3, 1'b0, 1'b0};
    tbl[5] = '{32'd0, 32'd1, 4'b0110, 32'hFFFFFFFF, 1'b0, 1'b0};
    tbl[6] = '{32'hFFFFFFFF, 32'd1, 4'b0111, 32'd1, 1'b0, 1'b0};
    tbl[7] = '{32'h1234, 32'h5678, 4'b0101, 32'd0, 1'b1, 1'b1};
    tbl[8] = '{32'd0, 32'd0, 4'b1100, 32'hFFFFFFFF, 1'b0, 1'b0};

    do_reset();
    #1;
    chk("rst_res", rsp_res, 0);
    chk("rst_zf", rsp_zf, 0);
    chk("rst_err", rsp_err, 0);
    step();

    // Vector table through requester 0, latency 2.
    rsp0_ready = 1;
    foreach (tbl[i]) begin
      req0_valid = 1;
      req0_op1 = tbl[i].op1;
      req0_op2 = tbl[i].op2;
      req0_sel = tbl[i].sel;
      #1 chk("tbl_accept", req0_ready, 1);
      step();
      req0_valid = 0;
      step();
      #1;
      chk("tbl_valid", rsp0_valid, 1);
      chk("tbl_res", rsp_res, tbl[i].res);
      chk("tbl_zf", rsp_zf, tbl[i].zf);
      chk("tbl_err", rsp_err, tbl[i].err);
      step();
      step();
    end

    // Tie from reset: 0 first, then 1, third pair 0.
    do_reset();
    gq.delete(); gc.delete();
    rsp0_ready = 1; rsp1_ready = 1;
    req0_valid = 1; req0_op1 = 9; req0_op2 = 9; req0_sel = 4'b0110;
    req1_valid = 1; req1_op1 = 3; req1_op2 = 9; req1_sel = 4'b0111;
    repeat (9) step();
    req0_valid = 0; req1_valid = 0;
    step();
    chk("tie_cnt", gq.size(), 3);
    if (gq.size() == 3) begin
      chk("tie_g0", gq[0], 0);
      chk("tie_g1", gq[1], 1);
      chk("tie_g2", gq[2], 0);
    end

    // Backpressure on requester 1 while requester 0 waits.
    rsp0_ready = 1; rsp1_ready = 0;
    req1_valid = 1; req1_op1 = 32'hF0F0F0F0;
    req1_op2 = 32'hFF00FF00; req1_sel = 4'b0000;
    step();
    req1_valid = 0;
    req0_valid = 1; req0_op1 = 1; req0_op2 = 1; req0_sel = 4'b0010;
    step();
    repeat (5) begin
      #1;
      chk("bp_valid", rsp1_valid, 1);
      chk("bp_res", rsp_res, 32'hF000F000);
      chk("bp_r0", req0_ready, 0);
      step();
    end
    rsp1_ready = 1;
    step();
    #1 chk("bp_idle", busy, 0);
    chk("bp_next", req0_ready, 1);
    step();
    req0_valid = 0;
    repeat (3) step();

    // Reset pulse in the middle of a response.
    rsp0_ready = 0;
    req0_valid = 1; req0_op1 = 4; req0_op2 = 4; req0_sel = 4'b0010;
    step();
    req0_valid = 0;
    step(); step();
    #1 chk("pre_rst_valid", rsp0_valid, 1);
    rst_n = 0;
    #1;
    chk("arst_valid", rsp0_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_sel", alu_sel, 0);
    chk("arst_err", rsp_err, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    req1_valid = 1; req1_op1 = 2; req1_op2 = 3; req1_sel = 4'b0001;
    rsp1_ready = 1;
    #1 chk("post_rst_r1", req1_ready, 1);
    step();
    req1_valid = 0;
    repeat (3) step();

    // Continuous pressure: strict alternation, one issue per 3 cycles.
    do_reset();
    gq.delete(); gc.delete();
    rsp0_ready = 1; rsp1_ready = 1;
    req0_valid = 1; req1_valid = 1;
    for (int k = 0; k < 24; k++) begin
      req0_op1 = $urandom; req0_op2 = $urandom; req0_sel = 4'b0010;
      req1_op1 = $urandom; req1_op2 = $urandom; req1_sel = 4'b0110;
      step();
    end
    req0_valid = 0; req1_valid = 0;
    step();
    chk("fair_cnt", gq.size(), 8);
    for (int k = 0; k < gq.size() && k < 8; k++) begin
      chk("fair_grant", gq[k], k % 2);
      if (k > 0) chk("fair_gap", gc[k] - gc[k-1], 3);
    end
    repeat (3) step();

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      req0_valid = ($urandom_range(0, 2) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      rsp0_ready = ($urandom_range(0, 1) != 0);
      rsp1_ready = ($urandom_range(0, 1) != 0);
      req0_op1 = $urandom; req0_op2 = ($urandom_range(0, 3) == 0) ? req0_op1 : $urandom;
      req1_op1 = $urandom; req1_op2 = ($urandom_range(0, 3) == 0) ? req1_op1 : $urandom;
      req0_sel = 4'($urandom);
      req1_sel = 4'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares the single combinational 32-bit ALU between two requesters (e.g. main datapath and address/branch unit) with a round-robin arbiter. Each request carries two operands and a 4-bit ALU select. The block drives the ALU from registered operands, captures result and zero flag, and returns them through a per-requester valid/ready response channel. Only one operation is in flight at a time.

Parameters:
WIDTH, 32, operand/result width; must match the ALU datapath width.
SEL_W, 4, ALU select width.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req0_valid  input  1  requester 0 has an operation.
req0_ready  output  1  requester 0 operation accepted this cycle.
req0_op1  input  WIDTH  requester 0 operand 1.
req0_op2  input  WIDTH  requester 0 operand 2.
req0_sel  input  SEL_W  requester 0 ALU select.
req1_valid, req1_ready, req1_op1, req1_op2, req1_sel  same as requester 0, for requester 1.
rsp0_valid  output  1  result ready for requester 0.
rsp0_ready  input  1  requester 0 consumes result.
rsp1_valid  output  1  result ready for requester 1.
rsp1_ready  input  1  requester 1 consumes result.
rsp_res  output  WIDTH  shared result bus, valid with rspN_valid.
rsp_zf  output  1  captured zero flag.
rsp_err  output  1  select was not a legal ALU code.
alu_op1  output  WIDTH  to ALU operand 1.
alu_op2  output  WIDTH  to ALU operand 2.
alu_sel  output  SEL_W  to ALU select.
alu_res  input  WIDTH  from ALU result.
alu_zf  input  1  from ALU zero flag.
busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset, asynchronous: state=IDLE, last_grant=1 so requester 0 wins the first tie. Operand, select, result, zf and err registers are all 0. All valid/ready outputs and busy are 0.
- alu_op1/alu_op2/alu_sel are driven from the operand registers at all times, never directly from request ports.
- IDLE:
  - Grant is combinational. With one valid, grant it. With both valid, grant the requester != last_grant.
  - reqN_ready=1 only for the granted requester, and only in IDLE.
  - On the accepting edge: latch op1/op2/sel, record grant, set last_grant=grant, go EXEC.
  - No request: stay in IDLE.
- EXEC, one cycle: the ALU sees the latched operands. On the edge, capture alu_res into rsp_res and alu_zf into rsp_zf. Set rsp_err=1 if sel is not one of {0000, 0001, 0010, 0110, 0111, 1100}. Go RESP.
- RESP:
  - rspN_valid=1 for the granted requester only.
  - rsp_res/rsp_zf/rsp_err stay stable until the handshake.
  - When rspN_valid && rspN_ready: go IDLE.
  - Otherwise hold indefinitely.
  - The other requester stays blocked (ready=0) throughout.
- Latency: accept edge at cycle N, rspN_valid high in cycle N+2. Minimum issue interval is 3 cycles per operation.
- Illegal select: the ALU result is passed through unmodified (expected 0, zf=1), with rsp_err=1.
- No width extension or truncation: the result is WIDTH bits exactly as the ALU returns it.
- Request ports are ignored outside IDLE. A requester dropping valid before acceptance is legal.
- rspN_ready while rspN_valid=0 is ignored.
- Reset asserted mid-EXEC or mid-RESP: the operation is discarded, with no response and no error. Outputs take reset values immediately (asynchronously).
- Fairness: under continuous requests from both, grants strictly alternate 0,1,0,1.

Test Plan:
- req0: op1=5, op2=7, sel=0010, alone, rsp0_ready=1 → req0_ready in cycle 0; rsp0_valid in cycle 2 with rsp_res=12, zf=0, err=0; busy high for cycles 1–2.
- Both valid from reset: req0 sel=0110 (9−9), req1 sel=0111 (3<9) → grant 0 first: rsp_res=0, zf=1. Then grant 1: rsp_res=1, zf=0. Third simultaneous pair → grant 0.
- Backpressure: req1 sel=0000 (F0F0F0F0 & FF00FF00), rsp1_ready held 0 for 5 cycles → rsp1_valid and rsp_res=F000F000 stay stable; req0_ready=0 throughout; IDLE reached the cycle after ready rises.
- Illegal sel=0101 from req0 → rsp_res=0, zf=1, err=1. Following legal op sel=1100 (0 NOR 0) → rsp_res=FFFFFFFF, err=0.
- Reset pulse during RESP → rsp0_valid=0, busy=0, alu_sel=0000 immediately. After release, a new req1 is granted (last_grant=1 is restored, so the tie rule favours requester 0).
- Continuous valid on both for 8 operations with rsp ready=1 → grant sequence 0,1,0,1,0,1,0,1; one response every 3 cycles.
